// File: rtl/key_schedule_stream.sv
// Streaming AES key expander: emits the complete AES-128/192/256 round-key
// schedule one 32-bit word per valid/ready handshake, key length chosen per run.
module key_schedule_stream #(
  parameter int MAX_NK = 8,
  parameter int IDX_W  = 6,
  parameter bit EN_192 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           key_len_i,
  input  logic [32*MAX_NK-1:0] key_i,
  output logic                 ready_o,
  output logic [31:0]          word_o,
  output logic [IDX_W-1:0]     word_idx_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic                 last_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int PW = $clog2(MAX_NK);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (b^254 by repeated squaring) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t           state;
  logic [PW-1:0]    p_r;
  logic [PW-1:0]    nkm1_r;
  logic [PW-1:0]    nkm2_r;
  logic             nk8_r;
  logic [7:0]       rcon_r;
  logic [IDX_W-1:0] last_idx_r;
  logic [31:0]      key_r [MAX_NK];
  logic [31:0]      hist  [MAX_NK-1];  // hist[k] holds w[i-1-k] while word_o is w[i]

  // Key-length decode for the start request.
  logic             legal;
  logic [PW-1:0]    nkm1_d;
  logic [PW-1:0]    nkm2_d;
  logic             nk8_d;
  logic [IDX_W-1:0] last_d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    legal  = 1'b1;
    nkm1_d = PW'(3);
    nkm2_d = PW'(2);
    nk8_d  = 1'b0;
    last_d = IDX_W'(43);
    case (key_len_i)
      2'd0: legal = 1'b1;
      2'd1: begin
        legal  = EN_192 && (MAX_NK >= 6);
        nkm1_d = PW'(5);
        nkm2_d = PW'(4);
        last_d = IDX_W'(51);
      end
      2'd2: begin
        legal  = (MAX_NK >= 8);
        nkm1_d = PW'(7);
        nkm2_d = PW'(6);
        nk8_d  = 1'b1;
        last_d = IDX_W'(59);
      end
      default: legal = 1'b0;
    endcase
  end

  // Next schedule word w[i+1] from the current word w[i] and the history window.
  logic [PW-1:0]    p_nxt;
  logic [IDX_W-1:0] idx_inc;
  logic             is_key;
  logic [31:0]      sb_in;
  logic [31:0]      sub;
  logic [31:0]      temp;
  logic [31:0]      word_nxt;
  logic             advance;

  always_comb begin
    p_nxt   = (p_r == nkm1_r) ? '0 : p_r + 1'b1;
    idx_inc = word_idx_o + 1'b1;
    is_key  = word_idx_o < IDX_W'(nkm1_r);
    sb_in   = (p_nxt == '0) ? {word_o[23:0], word_o[31:24]} : word_o;
    sub     = {sbox(sb_in[31:24]), sbox(sb_in[23:16]), sbox(sb_in[15:8]), sbox(sb_in[7:0])};
    temp    = word_o;
    if (p_nxt == '0)                    temp = sub ^ {rcon_r, 24'h000000};
    else if (nk8_r && p_nxt == PW'(4))  temp = sub;
    word_nxt = is_key ? key_r[p_nxt] : (hist[nkm2_r] ^ temp);
  end

  assign advance = (state == RUN) && word_valid_o && word_ready_i && !last_o;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      ready_o      <= 1'b1;
      word_o       <= '0;
      word_idx_o   <= '0;
      word_valid_o <= 1'b0;
      last_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rcon_r       <= 8'h01;
      p_r          <= '0;
      nkm1_r       <= PW'(3);
      nkm2_r       <= PW'(2);
      nk8_r        <= 1'b0;
      last_idx_r   <= IDX_W'(43);
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (legal) begin
              state        <= RUN;
              ready_o      <= 1'b0;
              word_o       <= key_i[32*MAX_NK-1 -: 32];
              word_idx_o   <= '0;
              word_valid_o <= 1'b1;
              last_o       <= 1'b0;
              rcon_r       <= 8'h01;
              p_r          <= '0;
              nkm1_r       <= nkm1_d;
              nkm2_r       <= nkm2_d;
              nk8_r        <= nk8_d;
              last_idx_r   <= last_d;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (word_valid_o && word_ready_i) begin
            if (last_o) begin
              state        <= FIN;
              word_valid_o <= 1'b0;
              done_o       <= 1'b1;
            end else begin
              word_o     <= word_nxt;
              word_idx_o <= idx_inc;
              last_o     <= (idx_inc == last_idx_r);
              p_r        <= p_nxt;
              if (!is_key && p_nxt == '0) rcon_r <= xtime(rcon_r);
            end
          end
        end
        FIN: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: key and history storage carry no reset; every entry is written before a run reads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i && legal) begin
      for (int k = 0; k < MAX_NK; k++) key_r[k] <= key_i[32*(MAX_NK-k)-1 -: 32];
    end
    if (advance) begin
      hist[0] <= word_o;
      for (int k = 1; k < MAX_NK-1; k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: doc/key_schedule_stream.md
Name: key_schedule_stream

Overview:
- Parametrised successor to the single-step AES-128 key expander.
- Produces the complete AES key schedule for AES-128, AES-192 and AES-256, with the key length selected at run time.
- Emits one 32-bit round-key word per accepted handshake on a valid/ready stream, with index and last markers.
- Sits between the key-load register interface and the round-key RAM or the cipher datapath of the encryption co-processor.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words; legal values 4, 6, 8; sizes the word window and key_i.
- IDX_W, 6, width of word_idx_o; must hold 4*(MAX_NK+7)-1.
- EN_192, 1, when 0, key_len_i=1 is rejected as illegal.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset, synchronous and active-high.
- start_i  in  1  start request; sampled only when ready_o=1.
- key_len_i  in  2  0=AES-128 (Nk=4), 1=AES-192 (Nk=6), 2=AES-256 (Nk=8), 3=illegal.
- key_i  in  32*MAX_NK  cipher key; w[0]=key_i[top 32 bits], w[1] next, and so on; unused low words ignored.
- ready_o  out  1  idle and able to accept start_i.
- word_o  out  32  current schedule word w[word_idx_o].
- word_idx_o  out  IDX_W  index i of word_o.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o.
- last_o  out  1  word_o is the final word, w[4*(Nr+1)-1].
- done_o  out  1  one-cycle pulse after the last word is accepted.
- err_o  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (rst=1 at a clk edge): ready_o=1; word_o, word_idx_o, word_valid_o, last_o, done_o and err_o all 0; FSM to IDLE; Rcon=8'h01.
- Reset has priority over all other inputs, including mid-stream. Any partial schedule is discarded and no done_o is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - ready_o=1.
  - start_i=1 with a legal key_len_i: latch Nk and Nr (10/12/14), load the key words into the Nk-word window, set Rcon=01 and position counter p=0. On the next cycle present word_o=w[0], word_idx_o=0, word_valid_o=1, and go to RUN.
  - start_i=1 with an illegal key_len_i (3, or 1 when EN_192=0): err_o=1 for one cycle, stay in IDLE.
- RUN:
  - ready_o=0.
  - start_i is ignored; key_i and key_len_i changes are ignored after the latch.
  - word_o, word_idx_o and last_o hold stable while word_valid_o=1 and word_ready_i=0.
  - On handshake (valid and ready), the next word w[i+1] appears on the following cycle, so throughput is one word per cycle under full ready.
- Word generation for i >= Nk, with p = i mod Nk kept as a wrapping counter (no divider):
  - p==0: temp = SubWord(RotWord(w[i-1])) XOR {Rcon,24'h0}; then Rcon = xtime(Rcon), i.e. shift left, XOR 8'h1B on carry out of bit 7.
  - Nk==8 and p==4: temp = SubWord(w[i-1]), no Rcon.
  - Otherwise: temp = w[i-1].
  - w[i] = w[i-Nk] XOR temp.
  - Words 0..Nk-1 are the key words passed through unchanged.
- RotWord rotates left by one byte. SubWord applies the AES S-box bytewise; 4 combinational S-box lookups are shared by both the RotWord and plain-SubWord cases.
- last_o=1 exactly when word_idx_o = 4*Nr+3, i.e. 43, 51 or 59.
- Handshake on the last word: word_valid_o goes to 0 next cycle, done_o=1 for that cycle (FIN), then IDLE with ready_o=1 on the cycle after.
- Rcon reaches 8'h36 for AES-128; the 8'h80 to 8'h1B reduction must be exercised.
- word_valid_o never drops mid-stream without a reset.

Test Plan:
- AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, word_ready_i=1 throughout -> 44 words on consecutive cycles; w[0]=2b7e1516, w[4]=a0fafe17, w[43]=b6630ca6 with last_o=1; done_o pulses once; ready_o returns 2 cycles after the last handshake.
- AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w[6]=fe0c91f7, w[51]=01002202 with last_o=1, 52 words total.
- AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only step), w[59]=706c631e with last_o=1.
- AES-128 with random word_ready_i stalls, plus start_i and key_i toggled mid-stream -> word_o and word_idx_o stable during stalls; identical 44-word sequence; no restart.
- key_len_i=3 with start_i=1 in IDLE -> err_o one cycle, ready_o stays 1, word_valid_o stays 0; same with key_len_i=1 when EN_192=0.
- rst=1 at word 20 of an AES-256 run -> next cycle all outputs 0 and ready_o=1; a new AES-128 start then produces the correct w[4]=a0fafe17, showing Rcon was reinitialised.
